// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame snapshot and sticky overflow dp.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int DIV_W    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] seg1_dig,
   input  logic [4:0] seg2_dig,
   input  logic [4:0] seg3_dig,
   input  logic [4:0] seg4_dig,
   input  logic       en4,
   output logic [3:0] seg_sel,
   output logic [7:0] seg_led,
   output logic       frame_done
);

   localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(SCAN_DIV - 1);

   localparam logic [1:0] IDX_D1 = 2'd0;
   localparam logic [1:0] IDX_D2 = 2'd1;
   localparam logic [1:0] IDX_D3 = 2'd2;
   localparam logic [1:0] IDX_D4 = 2'd3;

   // Active-low a..g glyph; anything outside 0..9 shows a dash.
   function automatic logic [6:0] seg_decode(input logic [4:0] val);
      logic [6:0] glyph;
      case (val)
         5'd0:    glyph = 7'h40;
         5'd1:    glyph = 7'h79;
         5'd2:    glyph = 7'h24;
         5'd3:    glyph = 7'h30;
         5'd4:    glyph = 7'h19;
         5'd5:    glyph = 7'h12;
         5'd6:    glyph = 7'h02;
         5'd7:    glyph = 7'h78;
         5'd8:    glyph = 7'h00;
         5'd9:    glyph = 7'h10;
         default: glyph = 7'h3F;
      endcase
      return glyph;
   endfunction

   function automatic logic [3:0] sel_decode(input logic [1:0] idx);
      logic [3:0] sel;
      case (idx)
         IDX_D1:  sel = 4'b1110;
         IDX_D2:  sel = 4'b1101;
         IDX_D3:  sel = 4'b1011;
         IDX_D4:  sel = 4'b0111;
         default: sel = 4'b1111;
      endcase
      return sel;
   endfunction

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [4:0]       snap1_q, snap2_q, snap3_q, snap4_q;
   logic [4:0]       snap1_d, snap2_d, snap3_d, snap4_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       sel_q, sel_d;
   logic [7:0]       led_q, led_d;
   logic             fd_q, fd_d;
   logic             tick_s;
   logic             capture_s;
   logic [4:0]       cur_dig_s;
   logic             blank_s;
   logic             dp_n_s;

   assign tick_s    = (cnt_q == CNT_MAX);
   assign capture_s = tick_s && (idx_q == IDX_D4);

   // Prescaler, digit index, snapshot and overflow next-state.
   always_comb begin
      cnt_d   = cnt_q + DIV_W'(1);
      idx_d   = idx_q;
      snap1_d = snap1_q;
      snap2_d = snap2_q;
      snap3_d = snap3_q;
      snap4_d = snap4_q;
      ovf_d   = ovf_q | en4;
      if (tick_s) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      if (capture_s) begin
         snap1_d = seg1_dig;
         snap2_d = seg2_dig;
         snap3_d = seg3_dig;
         snap4_d = seg4_dig;
      end else begin
         snap1_d = snap1_q;
      end
   end

   // Digit and blanking selection use the post-edge index and snapshot so slot 0 sees fresh captures.
   always_comb begin
      case (idx_d)
         IDX_D1:  cur_dig_s = snap1_d;
         IDX_D2:  cur_dig_s = snap2_d;
         IDX_D3:  cur_dig_s = snap3_d;
         IDX_D4:  cur_dig_s = snap4_d;
         default: cur_dig_s = 5'd0;
      endcase
`ifdef SEG_SCAN_LZB_EN
      case (idx_d)
         IDX_D2:  blank_s = (snap2_d == 5'd0) && (snap3_d == 5'd0) && (snap4_d == 5'd0);
         IDX_D3:  blank_s = (snap3_d == 5'd0) && (snap4_d == 5'd0);
         IDX_D4:  blank_s = (snap4_d == 5'd0);
         default: blank_s = 1'b0;
      endcase
`else
      blank_s = 1'b0;
`endif
      dp_n_s = !((idx_d == IDX_D4) && ovf_d);
   end

   // Output next-state: held between ticks, refreshed on every tick.
   always_comb begin
      sel_d = sel_q;
      led_d = led_q;
      fd_d  = 1'b0;
      if (tick_s) begin
         sel_d = sel_decode(idx_d);
         if (blank_s) begin
            led_d = {dp_n_s, 7'h7F};
         end else begin
            led_d = {dp_n_s, seg_decode(cur_dig_s)};
         end
         fd_d = capture_s;
      end else begin
         fd_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= IDX_D4;
         snap1_q <= 5'd0;
         snap2_q <= 5'd0;
         snap3_q <= 5'd0;
         snap4_q <= 5'd0;
         ovf_q   <= 1'b0;
         sel_q   <= 4'hF;
         led_q   <= 8'hFF;
         fd_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap1_q <= snap1_d;
         snap2_q <= snap2_d;
         snap3_q <= snap3_d;
         snap4_q <= snap4_d;
         ovf_q   <= ovf_d;
         sel_q   <= sel_d;
         led_q   <= led_d;
         fd_q    <= fd_d;
      end
   end

   assign seg_sel    = sel_q;
   assign seg_led    = led_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV = 4; expectations follow SEG_SCAN_LZB_EN.
module tb_seg_scan;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] seg1_dig, seg2_dig, seg3_dig, seg4_dig;
   logic       en4;
   logic [3:0] seg_sel;
   logic [7:0] seg_led;
   logic       frame_done;

   int n_run  = 0;
   int n_fail = 0;
   int edge_n = 0;

`ifdef SEG_SCAN_LZB_EN
   localparam logic [7:0] ZLED = 8'hFF;
`else
   localparam logic [7:0] ZLED = 8'hC0;
`endif

   seg_scan #(.SCAN_DIV(4), .DIV_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .seg1_dig   (seg1_dig),
      .seg2_dig   (seg2_dig),
      .seg3_dig   (seg3_dig),
      .seg4_dig   (seg4_dig),
      .en4        (en4),
      .seg_sel    (seg_sel),
      .seg_led    (seg_led),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic go(input int e);
      while (edge_n < e) begin
         @(posedge clk);
         #1;
         edge_n++;
      end
   endtask

   task automatic disp(input string tag, input logic [3:0] s, input logic [7:0] l, input logic fd);
      check({tag, ".sel"}, {4'h0, seg_sel}, {4'h0, s});
      check({tag, ".led"}, seg_led, l);
      check({tag, ".fd"}, {7'h0, frame_done}, {7'h0, fd});
   endtask

   initial begin
      reset    = 1'b1;
      seg1_dig = 5'd1;
      seg2_dig = 5'd2;
      seg3_dig = 5'd3;
      seg4_dig = 5'd4;
      en4      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      disp("rst", 4'hF, 8'hFF, 1'b0);
      reset  = 1'b0;
      edge_n = 0;

      go(3);  disp("pre", 4'hF, 8'hFF, 1'b0);
      go(4);  disp("e4", 4'hE, 8'hF9, 1'b1);
      go(5);  disp("e5", 4'hE, 8'hF9, 1'b0);
      go(6);  seg1_dig = 5'd7;
      go(7);  disp("iso7", 4'hE, 8'hF9, 1'b0);
      go(8);  disp("e8", 4'hD, 8'hA4, 1'b0);
      en4 = 1'b1;
      go(9);  en4 = 1'b0;
      go(12); disp("e12", 4'hB, 8'hB0, 1'b0);
      go(16); disp("e16dp", 4'h7, 8'h19, 1'b0);
      go(19); disp("e19", 4'h7, 8'h19, 1'b0);
      go(20); disp("e20cap", 4'hE, 8'hF8, 1'b1);
      go(24); disp("e24", 4'hD, 8'hA4, 1'b0);
      seg3_dig = 5'd12;
      go(28); disp("e28iso", 4'hB, 8'hB0, 1'b0);
      go(32); disp("e32dp", 4'h7, 8'h19, 1'b0);
      go(36); disp("e36", 4'hE, 8'hF8, 1'b1);
      go(40); disp("e40", 4'hD, 8'hA4, 1'b0);
      go(44); disp("e44dash", 4'hB, 8'hBF, 1'b0);
      go(48); disp("e48dp", 4'h7, 8'h19, 1'b0);
      go(50);

      #2;
      reset = 1'b1;
      #1;
      disp("arst", 4'hF, 8'hFF, 1'b0);
      seg1_dig = 5'd5;
      seg2_dig = 5'd0;
      seg3_dig = 5'd0;
      seg4_dig = 5'd0;
      #4;
      reset  = 1'b0;
      edge_n = 0;

      go(3);  disp("r_pre", 4'hF, 8'hFF, 1'b0);
      go(4);  disp("r4", 4'hE, 8'h92, 1'b1);
      go(8);  disp("r8z", 4'hD, ZLED, 1'b0);
      go(12); disp("r12z", 4'hB, ZLED, 1'b0);
      go(16); disp("r16z", 4'h7, ZLED, 1'b0);
      seg1_dig = 5'd0;
      go(20); disp("r20", 4'hE, 8'hC0, 1'b1);
      go(24); disp("r24z", 4'hD, ZLED, 1'b0);
      go(28); disp("r28z", 4'hB, ZLED, 1'b0);
      go(32); disp("r32z", 4'h7, ZLED, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
